// File: rtl/rpm_multi_counter.sv
// rpm_multi_counter: per-channel pulse counter over a shared gate window.
// Optional: define RPM_AVG_EN to report the mean of the last two windows.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   pulse_in   CH raw pulse inputs, asynchronous to clk
//   addr       bus address
//   ncs, noe   active-low chip select / output enable
//   sram_data  byte bus, driven only during a read (ncs=0, noe=0)
module rpm_multi_counter #(
  parameter int CH          = 4,
  parameter int W           = 16,
  parameter int DW          = 8,
  parameter int GATE_CYCLES = 50000,
  parameter int AW          = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] pulse_in,
  input  logic [AW-1:0] addr,
  input  logic          ncs,
  input  logic          noe,
  inout  wire  [DW-1:0] sram_data
);
  localparam int NB = (W + DW - 1) / DW;
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [W-1:0]  MAXV  = '1;
  localparam logic [TW-1:0] TLAST = TW'(GATE_CYCLES - 1);

  logic [CH-1:0] r_s1, r_s2, r_s3;
  logic [CH-1:0] w_edge;
  logic [TW-1:0] r_tmr;
  logic          w_term;
  logic [W-1:0]  r_cnt    [CH];
  logic [W-1:0]  w_cnt_nx [CH];
  logic [W-1:0]  w_res_nx [CH];
  logic [W-1:0]  r_res    [CH];
  logic [CH-1:0] r_sat, w_sat_nx, r_sat_last;
  logic          r_upd;
  logic [W-1:0]  r_hold;
  logic          w_rd;
  logic          w_cap;
  logic [W-1:0]  w_cap_val;
  logic [DW-1:0] w_dout;
  logic [NB*DW-1:0] w_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= pulse_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;
  assign w_term = (r_tmr == TLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_tmr <= '0;
    else if (w_term) r_tmr <= '0;
    else             r_tmr <= r_tmr + TW'(1);
  end

  // Next count includes this cycle's edge so a terminal-cycle
  // edge still lands in the closing window.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_cnt_nx[i] = r_cnt[i];
      if (w_edge[i] && (r_cnt[i] != MAXV))
        w_cnt_nx[i] = r_cnt[i] + W'(1);
      w_sat_nx[i] = r_sat[i] | (w_cnt_nx[i] == MAXV);
    end
  end

`ifdef RPM_AVG_EN
  logic [W-1:0] r_prev [CH];
  logic [W:0]   w_sum  [CH];

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_sum[i]    = {1'b0, w_cnt_nx[i]} + {1'b0, r_prev[i]};
      w_res_nx[i] = w_sum[i][W:1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) r_prev[i] <= '0;
    end else if (w_term) begin
      for (int i = 0; i < CH; i++) r_prev[i] <= w_cnt_nx[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < CH; i++) w_res_nx[i] = w_cnt_nx[i];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
        r_res[i] <= '0;
      end
      r_sat      <= '0;
      r_sat_last <= '0;
      r_upd      <= 1'b0;
    end else if (w_term) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
        r_res[i] <= w_res_nx[i];
      end
      r_sat      <= '0;
      r_sat_last <= w_sat_nx;
      r_upd      <= ~r_upd;
    end else begin
      for (int i = 0; i < CH; i++) r_cnt[i] <= w_cnt_nx[i];
      r_sat <= w_sat_nx;
    end
  end

  assign w_rd = ~ncs & ~noe;

  // Byte 0 comes from the live result and arms the hold register;
  // higher bytes come from hold so a multi-byte read never tears.
  always_comb begin
    w_dout    = '0;
    w_cap     = 1'b0;
    w_cap_val = '0;
    w_ext     = '0;
    for (int i = 0; i < CH; i++) begin
      for (int k = 0; k < NB; k++) begin
        if (addr == AW'(i * NB + k)) begin
          w_ext = '0;
          if (k == 0) begin
            w_ext[W-1:0] = r_res[i];
            w_cap        = 1'b1;
            w_cap_val    = r_res[i];
          end else begin
            w_ext[W-1:0] = r_hold;
          end
          w_dout = w_ext[k*DW +: DW];
        end
      end
    end
    if (addr == AW'(CH * NB)) begin
      w_dout[CH-1:0] = r_sat_last;
      w_dout[DW-1]   = r_upd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_hold <= '0;
    else if (w_rd && w_cap) r_hold <= w_cap_val;
  end

  assign sram_data = w_rd ? w_dout : {DW{1'bz}};

endmodule

// File: tb/tb_rpm_multi_counter.sv
// tb_rpm_multi_counter: randomized pulse stimulus against a window-count
// model; bus reads compared byte by byte.
`timescale 1ns/1ps
module tb_rpm_multi_counter;
  localparam int CH   = 4;
  localparam int W    = 9;
  localparam int DW   = 8;
  localparam int G    = 1200;
  localparam int AW   = 4;
  localparam int NB   = 2;
  localparam int MAXC = 511;
  localparam int NW   = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] pin = '0;
  logic [AW-1:0] addr = '0;
  logic          ncs = 1'b1;
  logic          noe = 1'b1;
  wire  [DW-1:0] sram_data;
  logic          tb_en = 1'b0;
  logic [DW-1:0] tb_pat = 8'h5A;

  int total = 0;
  int bad = 0;

  assign sram_data = tb_en ? tb_pat : {DW{1'bz}};

  rpm_multi_counter #(
    .CH(CH), .W(W), .DW(DW), .GATE_CYCLES(G), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .pulse_in(pin), .addr(addr),
    .ncs(ncs), .noe(noe), .sram_data(sram_data)
  );

  always #5 clk = ~clk;

  // Stimulus/model state. cyc = cycles since reset release; an edge
  // driven in cycle d is detected in cycle d+2, so it belongs to the
  // window (d+2)/G.
  int cyc = 0;
  int cnt [CH][NW];
  int mode [CH];
  int per [CH];
  int ph [CH];
  int tgt [CH];
  int hold = 0;

  always @(posedge clk) begin : drv
    logic nx;
    if (reset) begin
      cyc = 0;
      foreach (cnt[i, j]) cnt[i][j] = 0;
      #1;
      pin = '0;
    end else begin
      cyc = cyc + 1;
      #1;
      for (int i = 0; i < CH; i++) begin
        nx = 1'b0;
        case (mode[i])
          1: begin
            ph[i] = (ph[i] + 1) % per[i];
            nx = (ph[i] < per[i] / 2);
          end
          2: nx = 1'($urandom_range(0, 1));
          3: nx = (cyc == tgt[i]);
          default: nx = 1'b0;
        endcase
        if (nx && !pin[i] && ((cyc + 2) / G) < NW)
          cnt[i][(cyc + 2) / G]++;
        pin[i] = nx;
      end
    end
  end

  function automatic int raw(int ch, int w);
    if (w < 0 || w >= NW) return 0;
    return (cnt[ch][w] > MAXC) ? MAXC : cnt[ch][w];
  endfunction

  function automatic int res_at(int ch, int c);
    int lw;
    lw = c / G - 1;
`ifdef RPM_AVG_EN
    return (raw(ch, lw) + raw(ch, lw - 1)) / 2;
`else
    return raw(ch, lw);
`endif
  endfunction

  function automatic bit sat_at(int ch, int c);
    int lw;
    lw = c / G - 1;
    if (lw < 0 || lw >= NW) return 1'b0;
    return cnt[ch][lw] >= MAXC;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_mod(input int m);
    for (int n = 0; n <= G; n++) begin
      if (cyc % G == m) return;
      step(1);
    end
    total++;
    bad++;
    $display("FAIL wait_mod timeout cyc=%0d want_mod=%0d", cyc, m);
  endtask

  // Called at +2 of the read cycle; ends at +2 of the next cycle.
  task automatic rd(input int a, output logic [7:0] got,
                    output logic [7:0] exp);
    int i, k, r;
    addr = AW'(a);
    ncs = 1'b0;
    noe = 1'b0;
    #3;
    got = sram_data;
    exp = 8'h00;
    if (a < CH * NB) begin
      i = a / NB;
      k = a % NB;
      if (k == 0) begin
        r = res_at(i, cyc);
        exp = 8'(r);
        hold = r;
      end else begin
        exp = 8'(hold >> (8 * k));
      end
    end else if (a == CH * NB) begin
      exp = 8'(((cyc / G) % 2) * 128);
      for (int j = 0; j < CH; j++)
        if (sat_at(j, cyc)) exp[j] = 1'b1;
    end
    @(posedge clk);
    #2;
    ncs = 1'b1;
    noe = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    foreach (cnt[i, j]) cnt[i][j] = 0;
    cyc = 0;
    hold = 0;
    for (int i = 0; i < CH; i++) begin
      mode[i] = 0;
      ph[i] = 0;
    end
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] g, e;
    #2;
    tb_en = 1'b1;
    #1;
    total++;
    if (sram_data !== 8'h5A) begin
      bad++;
      $display("FAIL reset_hiz got=%h want=%h", sram_data, 8'h5A);
    end
    tb_en = 1'b0;
    do_reset();
    for (int a = 0; a <= CH * NB; a++) begin
      rd(a, g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset_rd a=%0d got=%h want=%h", a, g, e);
      end
    end
    step(G);
    rd(CH * NB, g, e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL idle_status1 got=%h want=%h", g, e);
    end
    addr = AW'(CH * NB);
    tb_en = 1'b1;
    for (int v = 0; v < 2; v++) begin
      ncs = 1'(v);
      noe = ~1'(v);
      #1;
      total++;
      if (sram_data !== 8'h5A) begin
        bad++;
        $display("FAIL hiz ncs=%b noe=%b got=%h want=%h",
                 ncs, noe, sram_data, 8'h5A);
      end
    end
    ncs = 1'b1;
    noe = 1'b1;
    tb_en = 1'b0;
    step(G);
    for (int a = 0; a <= CH * NB; a++) begin
      rd(a, g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL idle2_rd a=%0d got=%h want=%h", a, g, e);
      end
    end
  endtask

  task automatic test_rates();
    logic [7:0] g, e;
    int p [CH];
    p = '{10, 20, 50, 1000};
    do_reset();
    for (int i = 0; i < CH; i++) begin
      per[i] = p[i];
      ph[i] = $urandom_range(0, p[i] - 1);
      mode[i] = 1;
    end
    step(2 * G + 10);
    for (int a = 0; a <= CH * NB; a++) begin
      rd(a, g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL rates a=%0d got=%h want=%h", a, g, e);
      end
    end
  endtask

  task automatic test_sat();
    logic [7:0] g, e;
    int p [2];
    p = '{2, 10};
    for (int i = 0; i < CH; i++) mode[i] = 0;
    for (int s = 0; s < 2; s++) begin
      per[1] = p[s];
      ph[1] = 0;
      mode[1] = 1;
      step(2 * G);
      for (int a = 2; a <= CH * NB; a++) begin
        if (a == 2 || a == 3 || a == CH * NB) begin
          rd(a, g, e);
          total++;
          if (g !== e) begin
            bad++;
            $display("FAIL sat per=%0d a=%0d got=%h want=%h",
                     p[s], a, g, e);
          end
        end
      end
    end
  endtask

  task automatic test_coherence();
    logic [7:0] g, e;
    int seq [4];
    mode[1] = 0;
    per[0] = 4;
    ph[0] = 0;
    mode[0] = 1;
    step(2 * G);
    wait_mod(G - 2);
    rd(0, g, e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL coh_b0 got=%h want=%h", g, e);
    end
    per[0] = 6;
    step(2 * G);
    rd(1, g, e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL coh_b1_hold got=%h want=%h", g, e);
    end
    wait_mod(0);
    per[0] = 4;
    wait_mod(G - 1);
    seq = '{0, 1, 0, 1};
    for (int s = 0; s < 4; s++) begin
      rd(seq[s], g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL coh_term s=%0d got=%h want=%h", s, g, e);
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] g, e;
    do_reset();
    tgt[2] = G - 3;
    tgt[3] = G - 2;
    mode[2] = 3;
    mode[3] = 3;
    step(G + 2);
    for (int r = 0; r < 2; r++) begin
      rd(4, g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL edge_term r=%0d got=%h want=%h", r, g, e);
      end
      rd(6, g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL edge_next r=%0d got=%h want=%h", r, g, e);
      end
      step(G);
    end
    per[0] = 4;
    ph[0] = 0;
    mode[0] = 1;
    wait_mod(499);
    step(1);
    reset = 1'b1;
    foreach (cnt[i, j]) cnt[i][j] = 0;
    cyc = 0;
    hold = 0;
    for (int a = 0; a <= CH * NB; a++) begin
      rd(a, g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL mid_reset a=%0d got=%h want=%h", a, g, e);
      end
    end
    reset = 1'b0;
    wait_mod(G - 1);
    for (int r = 0; r < 2; r++) begin
      rd(0, g, e);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL post_reset r=%0d got=%h want=%h", r, g, e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] g, e;
    int a;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < CH; i++) begin
        per[i] = $urandom_range(2, 40);
        ph[i] = $urandom_range(0, per[i] - 1);
        mode[i] = $urandom_range(0, 2);
      end
      for (int n = 0; n < 30; n++) begin
        step($urandom_range(0, 60));
        a = $urandom_range(0, 15);
        rd(a, g, e);
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL random cyc=%0d a=%0d got=%h want=%h",
                   cyc, a, g, e);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      mode[i] = 0;
      per[i] = 2;
      ph[i] = 0;
      tgt[i] = -1;
    end
    test_reset();
    test_rates();
    test_sat();
    test_coherence();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
